// File: rtl/core_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_reset_sequencer                                                     |
// | Staggered multi-channel reset release followed by run-cycle supervision. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module core_reset_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER        = 1,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_req,
  input  logic              halt,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              done,
  output logic              timeout
);

  localparam int c_t_max = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int c_tw    = $clog2(c_t_max + 1);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TMO     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [c_tw-1:0]   t_q, t_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;

  logic [c_tw-1:0]   t_inc;
  logic [CNT_W-1:0]  run_inc;
  logic [NUM_CH-1:0] rel_hit;

  assign t_inc   = t_q + c_tw'(1);
  assign run_inc = (&run_q) ? run_q : run_q + CNT_W'(1);

  // Channel i releases on the edge where the timer reaches its own slot.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int c_rel = HOLD_CYCLES + i * STAGGER;
    assign rel_hit[i] = (t_inc == c_tw'(c_rel));
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    run_d     = run_q;
    done_d    = done_q;
    tmo_d     = tmo_q;

    if (soft_req) begin
      state_d   = ST_ASSERT;
      t_d       = '0;
      rst_out_d = '1;
      busy_d    = 1'b1;
      run_d     = '0;
      done_d    = 1'b0;
      tmo_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT, ST_RELEASE: begin
          t_d       = t_inc;
          rst_out_d = rst_out_q & ~rel_hit;
          if (rel_hit[NUM_CH-1]) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
          end else if (rel_hit[0]) begin
            state_d = ST_RELEASE;
          end
        end
        ST_RUN: begin
          // Halt wins over a timeout landing on the same edge.
          if (halt) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            run_d = run_inc;
            if (TIMEOUT_CYCLES != 0 && run_inc == c_timeout) begin
              state_d = ST_TMO;
              tmo_d   = 1'b1;
            end
          end
        end
        ST_DONE, ST_TMO: begin
          state_d = state_q;
        end
        default: begin
          state_d   = ST_ASSERT;
          t_d       = '0;
          rst_out_d = '1;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ASSERT;
      t_q       <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      run_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      run_q     <= run_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign rst_out    = rst_out_q;
  assign busy       = busy_q;
  assign run_cycles = run_q;
  assign done       = done_q;
  assign timeout    = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_core_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_reset_sequencer                                                  |
// | Directed bench over four parameterisations of core_reset_sequencer.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_core_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // dut0: defaults
  logic        soft0 = 1'b0, halt0 = 1'b0;
  logic [1:0]  rst_out0;
  logic        busy0, done0, tmo0;
  logic [31:0] run0;
  // dut1: four channels, wide stagger, no timeout
  logic        soft1 = 1'b0, halt1 = 1'b0;
  logic [3:0]  rst_out1;
  logic        busy1, done1, tmo1;
  logic [31:0] run1;
  // dut2: short timeout
  logic        soft2 = 1'b0, halt2 = 1'b0;
  logic [1:0]  rst_out2;
  logic        busy2, done2, tmo2;
  logic [31:0] run2;
  // dut3: zero stagger
  logic        soft3 = 1'b0, halt3 = 1'b0;
  logic [2:0]  rst_out3;
  logic        busy3, done3, tmo3;
  logic [31:0] run3;

  core_reset_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .soft_req(soft0), .halt(halt0),
    .rst_out(rst_out0), .busy(busy0), .run_cycles(run0), .done(done0), .timeout(tmo0)
  );

  core_reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(2), .STAGGER(3), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .soft_req(soft1), .halt(halt1),
    .rst_out(rst_out1), .busy(busy1), .run_cycles(run1), .done(done1), .timeout(tmo1)
  );

  core_reset_sequencer #(.TIMEOUT_CYCLES(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .soft_req(soft2), .halt(halt2),
    .rst_out(rst_out2), .busy(busy2), .run_cycles(run2), .done(done2), .timeout(tmo2)
  );

  core_reset_sequencer #(.NUM_CH(3), .HOLD_CYCLES(2), .STAGGER(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .soft_req(soft3), .halt(halt3),
    .rst_out(rst_out3), .busy(busy3), .run_cycles(run3), .done(done3), .timeout(tmo3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 ns after an edge; releases reset well before the next one.
  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (rst_out0 !== 2'b11 || busy0 !== 1'b1 || run0 !== 32'd0 || done0 !== 1'b0 || tmo0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: rst_out=%b busy=%b run=%0d done=%b tmo=%b, need 11 1 0 0 0",
               rst_out0, busy0, run0, done0, tmo0);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      logic [1:0] e_rst;
      logic       e_busy;
      step();
      e_rst  = (n < 4) ? 2'b11 : (n == 4) ? 2'b10 : 2'b00;
      e_busy = (n < 5);
      n_cmp++;
      if (rst_out0 !== e_rst || busy0 !== e_busy) begin
        n_bad++;
        $display("FAIL release_edge%0d: rst_out=%b busy=%b, need %b %b", n, rst_out0, busy0, e_rst, e_busy);
      end
    end
    n_cmp++;
    if (run0 !== 32'd1) begin
      n_bad++;
      $display("FAIL first_run_cycle: run=%0d, need 1", run0);
    end
  endtask

  task automatic test_halt();
    for (int k = 2; k <= 20; k++) step();
    n_cmp++;
    if (run0 !== 32'd20 || done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL run_count_20: run=%0d done=%b, need 20 0", run0, done0);
    end
    halt0 = 1'b1;
    step();
    halt0 = 1'b0;
    n_cmp++;
    if (done0 !== 1'b1 || run0 !== 32'd20 || tmo0 !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_capture: done=%b run=%0d tmo=%b, need 1 20 0", done0, run0, tmo0);
    end
    for (int c = 0; c < 50; c++) begin
      halt0 = (c == 10);
      step();
      n_cmp++;
      if (done0 !== 1'b1 || run0 !== 32'd20 || tmo0 !== 1'b0 || busy0 !== 1'b0) begin
        n_bad++;
        $display("FAIL done_hold_%0d: done=%b run=%0d tmo=%b busy=%b, need 1 20 0 0",
                 c, done0, run0, tmo0, busy0);
      end
    end
    halt0 = 1'b0;
  endtask

  task automatic test_soft_req();
    soft0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (rst_out0 !== 2'b11 || busy0 !== 1'b1 || done0 !== 1'b0 || run0 !== 32'd0) begin
        n_bad++;
        $display("FAIL soft_held_%0d: rst_out=%b busy=%b done=%b run=%0d, need 11 1 0 0",
                 c, rst_out0, busy0, done0, run0);
      end
    end
    soft0 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      logic [1:0] e_rst;
      step();
      e_rst = (n < 4) ? 2'b11 : (n == 4) ? 2'b10 : 2'b00;
      n_cmp++;
      if (rst_out0 !== e_rst || busy0 !== (n < 5)) begin
        n_bad++;
        $display("FAIL soft_release_edge%0d: rst_out=%b busy=%b, need %b %b", n, rst_out0, busy0, e_rst, n < 5);
      end
    end
    n_cmp++;
    if (run0 !== 32'd1) begin
      n_bad++;
      $display("FAIL soft_run_restart: run=%0d, need 1", run0);
    end
  endtask

  task automatic test_stagger();
    apply_reset();
    for (int n = 1; n <= 12; n++) begin
      logic [3:0] e1;
      logic [2:0] e3;
      step();
      for (int i = 0; i < 4; i++) e1[i] = (n < 2 + 3 * i);
      e3 = (n < 2) ? 3'b111 : 3'b000;
      n_cmp++;
      if (rst_out1 !== e1 || busy1 !== (n < 11)) begin
        n_bad++;
        $display("FAIL stagger_edge%0d: rst_out=%b busy=%b, need %b %b", n, rst_out1, busy1, e1, n < 11);
      end
      n_cmp++;
      if (rst_out3 !== e3 || busy3 !== (n < 2)) begin
        n_bad++;
        $display("FAIL nostagger_edge%0d: rst_out=%b busy=%b, need %b %b", n, rst_out3, busy3, e3, n < 2);
      end
    end
    n_cmp++;
    if (run1 !== 32'd1) begin
      n_bad++;
      $display("FAIL stagger_run: run=%0d, need 1", run1);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int n = 1; n <= 14; n++) step();
    n_cmp++;
    if (run2 !== 32'd9 || tmo2 !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_timeout: run=%0d tmo=%b, need 9 0", run2, tmo2);
    end
    step();
    n_cmp++;
    if (run2 !== 32'd10 || tmo2 !== 1'b1 || done2 !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_hit: run=%0d tmo=%b done=%b, need 10 1 0", run2, tmo2, done2);
    end
    halt2 = 1'b1;
    for (int c = 0; c < 3; c++) step();
    halt2 = 1'b0;
    n_cmp++;
    if (run2 !== 32'd10 || tmo2 !== 1'b1 || done2 !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_hold: run=%0d tmo=%b done=%b, need 10 1 0", run2, tmo2, done2);
    end
    soft2 = 1'b1;
    step();
    soft2 = 1'b0;
    n_cmp++;
    if (rst_out2 !== 2'b11 || tmo2 !== 1'b0 || run2 !== 32'd0) begin
      n_bad++;
      $display("FAIL timeout_clear: rst_out=%b tmo=%b run=%0d, need 11 0 0", rst_out2, tmo2, run2);
    end
    for (int n = 1; n <= 14; n++) step();
    n_cmp++;
    if (run2 !== 32'd9) begin
      n_bad++;
      $display("FAIL rerun_9: run=%0d, need 9", run2);
    end
    halt2 = 1'b1;
    step();
    halt2 = 1'b0;
    n_cmp++;
    if (done2 !== 1'b1 || tmo2 !== 1'b0 || run2 !== 32'd9) begin
      n_bad++;
      $display("FAIL halt_vs_timeout: done=%b tmo=%b run=%0d, need 1 0 9", done2, tmo2, run2);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int n = 1; n <= 6; n++) step();
    n_cmp++;
    if (rst_out1 !== 4'b1100) begin
      n_bad++;
      $display("FAIL mid_release_state: rst_out=%b, need 1100", rst_out1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rst_out1 !== 4'b1111 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: rst_out=%b busy=%b, need 1111 1", rst_out1, busy1);
    end
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      logic [3:0] e1;
      step();
      for (int i = 0; i < 4; i++) e1[i] = (n < 2 + 3 * i);
      n_cmp++;
      if (rst_out1 !== e1 || busy1 !== (n < 11)) begin
        n_bad++;
        $display("FAIL restart_edge%0d: rst_out=%b busy=%b, need %b %b", n, rst_out1, busy1, e1, n < 11);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_halt();
    test_soft_req();
    test_stagger();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
